// File: rtl/carfield_domain_pwr_seq.sv
// Per-domain clock-enable / reset / isolation sequencer for the gateable
// Carfield subdomains (0 Periph, 1 Safed, 2 Secd, 3 IntCluster, 4 FPCluster, 5 L2).
// Domains are serviced one at a time, lowest index first. Every output is a
// flop whose next value is decided by the FSM transition that takes the domain
// into its next phase. A power-up therefore takes 10 cycles from the decision
// edge with the default RstHoldCycles.
module carfield_domain_pwr_seq #(
    parameter int unsigned NumDomains       = 6,
    parameter int unsigned RstHoldCycles    = 8,
    parameter int unsigned IsoTimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumDomains-1:0] domain_en_req_i,
    input  logic [NumDomains-1:0] domain_iso_ack_i,
    input  logic [NumDomains-1:0] timeout_clr_i,
    output logic [NumDomains-1:0] domain_clk_en_o,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic [NumDomains-1:0] domain_iso_o,
    output logic [NumDomains-1:0] domain_state_o,
    output logic                  busy_o,
    output logic [NumDomains-1:0] timeout_o
);

    localparam int unsigned MaxCycles = (RstHoldCycles > IsoTimeoutCycles) ? RstHoldCycles
                                                                           : IsoTimeoutCycles;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);
    localparam int unsigned IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam logic [CntW-1:0] RstLast = CntW'(RstHoldCycles - 1);
    localparam logic [CntW-1:0] IsoLast = CntW'(IsoTimeoutCycles - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PU_CLK = 3'd1,
        PU_REL = 3'd2,
        PD_ISO = 3'd3,
        PD_RST = 3'd4,
        PD_CLK = 3'd5
    } state_e;

    state_e                state_r, state_nxt_s;
    logic [IdxW-1:0]       sel_r, sel_nxt_s;
    logic [CntW-1:0]       cnt_r, cnt_nxt_s;
    logic [NumDomains-1:0] clk_en_r, clk_en_nxt_s;
    logic [NumDomains-1:0] rst_n_r, rst_n_nxt_s;
    logic [NumDomains-1:0] iso_r, iso_nxt_s;
    logic [NumDomains-1:0] up_r, up_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic [NumDomains-1:0] timeout_r, timeout_nxt_s, timeout_set_s;
    logic [NumDomains-1:0] mismatch_s;
    logic                  pick_valid_s;
    logic [IdxW-1:0]       pick_idx_s;

    // Find the lowest-index domain whose request differs from its current state.
    always_comb begin
        mismatch_s   = domain_en_req_i ^ up_r;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = NumDomains - 1; k >= 0; k--) begin
            if (mismatch_s[k]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = IdxW'(k);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Next-state and next-output logic; outputs of unselected domains hold.
    always_comb begin
        state_nxt_s   = state_r;
        sel_nxt_s     = sel_r;
        clk_en_nxt_s  = clk_en_r;
        rst_n_nxt_s   = rst_n_r;
        iso_nxt_s     = iso_r;
        up_nxt_s      = up_r;
        busy_nxt_s    = busy_r;
        timeout_set_s = '0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    sel_nxt_s  = pick_idx_s;
                    busy_nxt_s = 1'b1;
                    if (domain_en_req_i[pick_idx_s]) begin
                        state_nxt_s              = PU_CLK;
                        clk_en_nxt_s[pick_idx_s] = 1'b1;
                        rst_n_nxt_s[pick_idx_s]  = 1'b0;
                    end else begin
                        state_nxt_s           = PD_ISO;
                        iso_nxt_s[pick_idx_s] = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PU_CLK: begin
                if (cnt_r == RstLast) begin
                    state_nxt_s         = PU_REL;
                    rst_n_nxt_s[sel_r]  = 1'b1;
                end else begin
                    state_nxt_s = PU_CLK;
                end
            end
            PU_REL: begin
                state_nxt_s      = IDLE;
                iso_nxt_s[sel_r] = 1'b0;
                up_nxt_s[sel_r]  = 1'b1;
                busy_nxt_s       = 1'b0;
            end
            PD_ISO: begin
                if (domain_iso_ack_i[sel_r]) begin
                    state_nxt_s        = PD_RST;
                    rst_n_nxt_s[sel_r] = 1'b0;
                end else if (cnt_r == IsoLast) begin
                    // Give up waiting for the drain but still bring the domain down.
                    state_nxt_s          = PD_RST;
                    rst_n_nxt_s[sel_r]   = 1'b0;
                    timeout_set_s[sel_r] = 1'b1;
                end else begin
                    state_nxt_s = PD_ISO;
                end
            end
            PD_RST: begin
                if (cnt_r == RstLast) begin
                    state_nxt_s         = PD_CLK;
                    clk_en_nxt_s[sel_r] = 1'b0;
                    up_nxt_s[sel_r]     = 1'b0;
                end else begin
                    state_nxt_s = PD_RST;
                end
            end
            PD_CLK: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Phase counter restarts on every state entry and idles at zero.
    always_comb begin
        if ((state_nxt_s != state_r) || (state_r == IDLE)) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CntW'(1);
        end
    end

    // Sticky timeout flags: a new timeout beats a simultaneous clear.
    always_comb begin
        timeout_nxt_s = (timeout_r & ~timeout_clr_i) | timeout_set_s;
    end

    // State, counter and output registers; reset parks every domain down and isolated.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            sel_r     <= '0;
            cnt_r     <= '0;
            clk_en_r  <= '0;
            rst_n_r   <= '0;
            iso_r     <= {NumDomains{1'b1}};
            up_r      <= '0;
            busy_r    <= 1'b0;
            timeout_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            sel_r     <= sel_nxt_s;
            cnt_r     <= cnt_nxt_s;
            clk_en_r  <= clk_en_nxt_s;
            rst_n_r   <= rst_n_nxt_s;
            iso_r     <= iso_nxt_s;
            up_r      <= up_nxt_s;
            busy_r    <= busy_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign domain_clk_en_o = clk_en_r;
    assign domain_rst_no   = rst_n_r;
    assign domain_iso_o    = iso_r;
    assign domain_state_o  = up_r;
    assign busy_o          = busy_r;
    assign timeout_o       = timeout_r;

endmodule

// File: tb/tb_carfield_domain_pwr_seq.sv
// Directed bench for the domain power sequencer. Cycle n is counted from the
// cycle whose closing edge makes the sequencing decision; outputs are sampled
// on the falling edge.
module tb_carfield_domain_pwr_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] req, ack, tclr;
    logic [5:0] clk_en, rst_n, iso, state, timeout;
    logic       busy;
    int         n_checks = 0;
    int         n_fail   = 0;

    carfield_domain_pwr_seq #(
        .NumDomains(6), .RstHoldCycles(8), .IsoTimeoutCycles(1024)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .domain_en_req_i(req), .domain_iso_ack_i(ack), .timeout_clr_i(tclr),
        .domain_clk_en_o(clk_en), .domain_rst_no(rst_n), .domain_iso_o(iso),
        .domain_state_o(state), .busy_o(busy), .timeout_o(timeout)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [5:0] e_clk, input logic [5:0] e_rst,
                             input logic [5:0] e_iso, input logic [5:0] e_st, input logic e_busy);
        check({tag, ".clk_en"}, {26'd0, clk_en}, {26'd0, e_clk});
        check({tag, ".rst_n"},  {26'd0, rst_n},  {26'd0, e_rst});
        check({tag, ".iso"},    {26'd0, iso},    {26'd0, e_iso});
        check({tag, ".state"},  {26'd0, state},  {26'd0, e_st});
        check({tag, ".busy"},   {31'd0, busy},   {31'd0, e_busy});
    endtask

    initial begin
        rst = 1'b1; req = 6'h00; ack = 6'h00; tclr = 6'h00;
        adv(3);
        // 1: reset values, then held with no requests
        check_all("rst", 6'h00, 6'h00, 6'h3F, 6'h00, 1'b0);
        check("rst.timeout", {26'd0, timeout}, 32'd0);
        rst = 1'b0;
        adv(20);
        check_all("idle", 6'h00, 6'h00, 6'h3F, 6'h00, 1'b0);

        // 2: single power-up of domain 0
        req = 6'h01;
        adv(1);  check_all("pu0.c1", 6'h01, 6'h00, 6'h3F, 6'h00, 1'b1);
        adv(7);  check_all("pu0.c8", 6'h01, 6'h00, 6'h3F, 6'h00, 1'b1);
        adv(1);  check_all("pu0.c9", 6'h01, 6'h01, 6'h3F, 6'h00, 1'b1);
        adv(1);  check_all("pu0.c10", 6'h01, 6'h01, 6'h3E, 6'h01, 1'b0);

        // 3: all domains from reset, in index order, 10 cycles each
        rst = 1'b1; req = 6'h3F;
        adv(2);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            adv(1);
            check_all("all.clk", 6'((7'd2 << k) - 7'd1), 6'((7'd1 << k) - 7'd1),
                      6'h3F & ~6'((7'd1 << k) - 7'd1), 6'((7'd1 << k) - 7'd1), 1'b1);
            adv(8);
            check("all.rel", {26'd0, rst_n}, {26'd0, 6'((7'd2 << k) - 7'd1)});
            adv(1);
            check("all.up", {26'd0, state}, {26'd0, 6'((7'd2 << k) - 7'd1)});
            check("all.busy", {31'd0, busy}, 32'd0);
        end
        check_all("all.done", 6'h3F, 6'h3F, 6'h00, 6'h3F, 1'b0);

        // 4: power down domain 3, ack arrives after 5 cycles
        req = 6'h37;
        adv(1);  check_all("pd3.c1", 6'h3F, 6'h3F, 6'h08, 6'h3F, 1'b1);
        adv(4);  check("pd3.c5.rst_n", {26'd0, rst_n}, 32'h3F);
        ack = 6'h08;
        adv(1);  check_all("pd3.c6", 6'h3F, 6'h37, 6'h08, 6'h3F, 1'b1);
        adv(7);  check_all("pd3.c13", 6'h3F, 6'h37, 6'h08, 6'h3F, 1'b1);
        adv(1);  check_all("pd3.c14", 6'h37, 6'h37, 6'h08, 6'h37, 1'b1);
        adv(1);  check_all("pd3.c15", 6'h37, 6'h37, 6'h08, 6'h37, 1'b0);
        ack = 6'h00;

        // 5: power down domain 1 with no ack -> timeout, then clear
        req = 6'h35;
        adv(1);    check_all("to.c1", 6'h3F & 6'h37, 6'h37, 6'h0A, 6'h37, 1'b1);
        adv(1023); check("to.c1024.rst_n", {26'd0, rst_n}, 32'h37);
        check("to.c1024.timeout", {26'd0, timeout}, 32'h00);
        adv(1);    check("to.c1025.rst_n", {26'd0, rst_n}, 32'h35);
        check("to.c1025.timeout", {26'd0, timeout}, 32'h02);
        adv(8);    check_all("to.c1033", 6'h35, 6'h35, 6'h0A, 6'h35, 1'b1);
        adv(1);    check("to.c1034.busy", {31'd0, busy}, 32'd0);
        adv(5);    check("to.sticky", {26'd0, timeout}, 32'h02);
        tclr = 6'h02;
        adv(1);    tclr = 6'h00;
        check("to.clr", {26'd0, timeout}, 32'h00);

        // 6: reset during PU_CLK of domain 2 aborts immediately, then restarts
        rst = 1'b1; req = 6'h04;
        adv(2);
        rst = 1'b0;
        adv(3);    check("ab.c3.clk_en", {26'd0, clk_en}, 32'h04);
        rst = 1'b1;
        #1;        check_all("ab.async", 6'h00, 6'h00, 6'h3F, 6'h00, 1'b0);
        adv(1);
        rst = 1'b0;
        adv(1);    check_all("ab.re.c1", 6'h04, 6'h00, 6'h3F, 6'h00, 1'b1);
        adv(9);    check_all("ab.re.c10", 6'h04, 6'h04, 6'h3B, 6'h04, 1'b0);

        // 7: ack already high -> one cycle in PD_ISO; mid-sequence request ignored
        ack = 6'h04; req = 6'h00;
        adv(1);    check_all("fast.c1", 6'h04, 6'h04, 6'h3F, 6'h04, 1'b1);
        adv(1);    check("fast.c2.rst_n", {26'd0, rst_n}, 32'h00);
        req = 6'h01;
        adv(8);    check_all("fast.c10", 6'h00, 6'h00, 6'h3F, 6'h00, 1'b1);
        adv(1);    check_all("fast.c11", 6'h00, 6'h00, 6'h3F, 6'h00, 1'b0);
        adv(1);    check_all("fast.c12", 6'h01, 6'h00, 6'h3F, 6'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
